// File: rtl/vx_issue_sched_pkg.sv
// Shared definitions for the issue-slot warp scheduler: index-width helper
// and the naming of the per-warp {rd,rs1,rs2,rs3} register tuple slots.
package vx_issue_sched_pkg;

  function automatic int log2_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot positions inside a packed [3:0][NR_W-1:0] register tuple; rd sits in the MSBs.
  typedef enum logic [1:0] {
    FLD_RS3 = 2'd0,
    FLD_RS2 = 2'd1,
    FLD_RS1 = 2'd2,
    FLD_RD  = 2'd3
  } reg_fld_e;

  localparam int NUM_FLDS = 4;

endpackage

// File: rtl/vx_issue_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request scanning upward from rr_ptr,
// wrapping modulo NUM_REQS. Purely combinational, no lock.
module vx_issue_sched_rr_arbiter
  import vx_issue_sched_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = log2_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [IDX_W-1:0] idx;

  // NUM_REQS is a power of two, so the IDX_W-bit add wraps naturally.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = rr_ptr + IDX_W'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    grant_oh[grant_idx] = grant_valid;
  end

endmodule

// File: rtl/vx_issue_sched.sv
// Per-issue-slot warp scheduler: hazard-checked round-robin selection,
// per-warp in-use register bitmaps, and a one-entry registered output stage.
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int NUM_REGS  = 64,
  parameter  int DATAW     = 128,
  parameter  int STALL_SAT = 16,
  localparam int WID_W     = log2_width(NUM_WARPS),
  localparam int NR_W      = log2_width(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_WARPS-1:0]              in_valid,
  output logic [NUM_WARPS-1:0]              in_ready,
  input  logic [NUM_WARPS*DATAW-1:0]        in_data,
  input  logic [NUM_WARPS*NUM_FLDS*NR_W-1:0] in_regs,
  input  logic [NUM_WARPS-1:0]              in_wb,
  input  logic                              wb_valid,
  input  logic                              wb_eop,
  input  logic [WID_W-1:0]                  wb_wid,
  input  logic [NR_W-1:0]                   wb_rd,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATAW-1:0]                  out_data,
  output logic [WID_W-1:0]                  out_wid,
  output logic [STALL_SAT-1:0]              stall_cycles
);

  // Handshake: a transfer happens on a cycle where valid && ready are both high.
  // in_ready is combinational and one-hot (or zero) on the granted warp;
  // out_valid stays high until out_ready is seen, and a new grant may load the
  // output stage on the very cycle the current entry is accepted.

  typedef logic [NUM_FLDS-1:0][NR_W-1:0] reg_tuple_t;

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse, inuse_eff, inuse_n;
  logic [NUM_WARPS-1:0] elig, req, grant_oh;
  logic [WID_W-1:0]     rr_ptr, grant_idx;
  logic                 grant_valid, out_free, stall_inc;
  reg_tuple_t           tup, grant_tup;

  // Eop writeback clears are bypassed into this cycle's hazard check.
  always_comb begin
    inuse_eff = inuse;
    if (wb_valid && wb_eop) inuse_eff[wb_wid][wb_rd] = 1'b0;
  end

  always_comb begin
    elig = '0;
    tup  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      tup     = in_regs[w*NUM_FLDS*NR_W +: NUM_FLDS*NR_W];
      elig[w] = in_valid[w];
      for (int f = 0; f < NUM_FLDS; f++) begin
        if (inuse_eff[w][tup[f]]) elig[w] = 1'b0;
      end
    end
  end

  assign out_free = !out_valid || out_ready;
  assign req      = (reset_n && out_free) ? elig : '0;

  vx_issue_sched_rr_arbiter #(
    .NUM_REQS (NUM_WARPS)
  ) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign in_ready  = grant_oh;
  assign grant_tup = in_regs[grant_idx*NUM_FLDS*NR_W +: NUM_FLDS*NR_W];

  // Set is applied after the clear, so a same-bit collision ends up set.
  always_comb begin
    inuse_n = inuse_eff;
    if (grant_valid && in_wb[grant_idx]) inuse_n[grant_idx][grant_tup[FLD_RD]] = 1'b1;
  end

  assign stall_inc = (|in_valid) && out_free && !grant_valid && !(&stall_cycles);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inuse        <= '0;
      rr_ptr       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_wid      <= '0;
      stall_cycles <= '0;
    end else begin
      inuse <= inuse_n;
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*DATAW +: DATAW];
        out_wid   <= grant_idx;
        rr_ptr    <= grant_idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (stall_inc) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // A final writeback to a register that was never marked busy is a protocol slip upstream.
  wb_unmarked_a: assert property (@(posedge clk) disable iff (!reset_n)
    (wb_valid && wb_eop) |-> inuse[wb_wid][wb_rd])
    else $error("eop writeback to a register that is not in use");

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed bench for vx_issue_sched: a per-cycle reference model of the
// scheduling rules plus literal checks for the grant order and corner cases.
module tb_vx_issue_sched;

  localparam int NW = 4;
  localparam int NR = 64;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int RW = 6;
  localparam int TW = 4 * RW;

  logic              clk, reset_n;
  logic [NW-1:0]     in_valid, in_ready, in_wb;
  logic [NW*DW-1:0]  in_data;
  logic [NW*TW-1:0]  in_regs;
  logic              wb_valid, wb_eop, out_valid, out_ready;
  logic [1:0]        wb_wid, out_wid;
  logic [RW-1:0]     wb_rd;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     stall_cycles;

  int checks = 0;
  int errors = 0;

  vx_issue_sched dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_regs      (in_regs),
    .in_wb        (in_wb),
    .wb_valid     (wb_valid),
    .wb_eop       (wb_eop),
    .wb_wid       (wb_wid),
    .wb_rd        (wb_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_wid      (out_wid),
    .stall_cycles (stall_cycles)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [NW-1:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NW - 1; i >= 0; i--) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check_grants(input string name);
    chk({name, "_count"}, DW'(got_q.size()), DW'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) chk(name, DW'(got_q.pop_front()), DW'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- reference model ----------------
  bit           m_inuse [NW][NR];
  int           m_rr = 0;
  bit           m_ov = 0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]   m_wid = '0;
  int           m_stall = 0;

  function automatic bit reg_busy(input int w, input int r);
    return m_inuse[w][r] && !(wb_valid && wb_eop && int'(wb_wid) == w && int'(wb_rd) == r);
  endfunction

  function automatic bit warp_ok(input int w);
    bit ok;
    ok = in_valid[w];
    for (int f = 0; f < 4; f++) if (reg_busy(w, int'(in_regs[w*TW + f*RW +: RW]))) ok = 0;
    return ok;
  endfunction

  always @(negedge clk) begin
    int g;
    bit free;
    logic [NW-1:0] exp_rdy;
    if (in_ready != '0) got_q.push_back(oh_idx(in_ready));
    if (!reset_n) begin
      foreach (m_inuse[w, r]) m_inuse[w][r] = 0;
      m_rr = 0; m_ov = 0; m_data = '0; m_wid = '0; m_stall = 0;
      chk("rst_in_ready", DW'(in_ready), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_wid", DW'(out_wid), '0);
      chk("rst_stall", DW'(stall_cycles), '0);
    end else begin
      free = !m_ov || out_ready;
      g = -1;
      for (int k = 0; k < NW; k++) begin
        int w;
        w = (m_rr + k) % NW;
        if (g < 0 && free && warp_ok(w)) g = w;
      end
      exp_rdy = (g >= 0) ? NW'(1 << g) : '0;
      chk("in_ready", DW'(in_ready), DW'(exp_rdy));
      chk("out_valid", DW'(out_valid), DW'(m_ov));
      chk("out_data", out_data, m_data);
      if (m_ov) chk("out_wid", DW'(out_wid), DW'(m_wid));
      chk("stall_cycles", DW'(stall_cycles), DW'(m_stall));
      if (wb_valid && wb_eop) m_inuse[wb_wid][wb_rd] = 0;
      if (g >= 0) begin
        if (in_wb[g]) m_inuse[g][in_regs[g*TW + 3*RW +: RW]] = 1;
        m_ov = 1;
        m_data = in_data[g*DW +: DW];
        m_wid = 2'(g);
        m_rr = (g + 1) % NW;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if ((|in_valid) && free && g < 0 && m_stall != (1 << SW) - 1) m_stall++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_warp(input int w, input bit v, input int rd, input int rs1,
                          input int rs2, input int rs3, input bit wb);
    in_valid[w] = v;
    in_wb[w] = wb;
    in_regs[w*TW +: TW] = {RW'(rd), RW'(rs1), RW'(rs2), RW'(rs3)};
    in_data[w*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_all();
    in_valid = '0;
    in_wb = '0;
    wb_valid = 1'b0;
    wb_eop = 1'b0;
  endtask

  task automatic set_wb(input bit v, input bit eop, input int wid, input int rd);
    wb_valid = v;
    wb_eop = eop;
    wb_wid = 2'(wid);
    wb_rd = RW'(rd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d0, d1;
    reset_n = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    in_regs = '0;
    wb_wid = '0;
    wb_rd = '0;
    clear_all();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_valid", DW'(out_valid), '0);
    chk("post_reset_stall", DW'(stall_cycles), '0);

    // all four warps ready with disjoint registers: strict rotation
    for (int w = 0; w < NW; w++) set_warp(w, 1, 4*w + 1, 4*w + 2, 4*w + 3, 4*w + 4, 0);
    repeat (5) tick();
    clear_all();
    tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_grants("rotation");
    chk("rotation_stall", DW'(stall_cycles), '0);

    // RAW on r5: blocked through a non-eop beat, released by eop bypass
    set_warp(1, 1, 5, 10, 11, 12, 1);
    tick();
    set_warp(1, 1, 6, 5, 13, 14, 0);
    repeat (2) tick();
    set_wb(1, 0, 1, 5);
    #1 chk("noneop_blocked", DW'(in_ready), '0);
    tick();
    set_wb(1, 1, 1, 5);
    #1 chk("eop_bypass_grant", DW'(in_ready), DW'(4'b0010));
    tick();
    clear_all();
    tick();
    exp_q = '{2'd1, 2'd1};
    check_grants("raw");
    chk("raw_stall", DW'(stall_cycles), DW'(3));

    // downstream back-pressure holds the output stage
    set_warp(0, 1, 1, 2, 3, 4, 0);
    d0 = in_data[0 +: DW];
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_warp(0, 1, 1, 2, 3, 4, 0);
      #1;
      chk("bp_in_ready", DW'(in_ready), '0);
      chk("bp_out_data", out_data, d0);
      tick();
    end
    out_ready = 1'b1;
    d1 = in_data[0 +: DW];
    #1 chk("bp_release_grant", DW'(in_ready), DW'(4'b0001));
    tick();
    chk("bp_release_data", out_data, d1);
    clear_all();
    tick();
    exp_q = '{2'd0, 2'd0};
    check_grants("backpressure");
    chk("bp_stall", DW'(stall_cycles), DW'(3));

    // same-cycle set and clear of warp2 r7 resolves to set
    set_warp(2, 1, 7, 20, 21, 22, 1);
    tick();
    set_warp(2, 1, 7, 23, 24, 25, 1);
    set_wb(1, 1, 2, 7);
    tick();
    set_wb(0, 0, 0, 0);
    set_warp(2, 1, 30, 7, 26, 27, 0);
    #1 chk("setwins_blocked", DW'(in_ready), '0);
    tick();
    set_wb(1, 1, 2, 7);
    #1 chk("setwins_release", DW'(in_ready), DW'(4'b0100));
    tick();
    clear_all();

    // register 0 is tracked like any other
    set_warp(3, 1, 0, 40, 41, 42, 1);
    tick();
    set_warp(3, 1, 1, 43, 44, 0, 0);
    #1 chk("r0_blocked", DW'(in_ready), '0);
    tick();
    set_wb(1, 1, 3, 0);
    #1 chk("r0_release", DW'(in_ready), DW'(4'b1000));
    tick();
    clear_all();
    tick();
    exp_q = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    check_grants("collide_r0");
    chk("collide_stall", DW'(stall_cycles), DW'(5));

    // long block saturates the stall counter
    set_warp(0, 1, 9, 1, 2, 3, 1);
    d0 = in_data[0 +: DW];
    tick();
    set_warp(0, 1, 10, 9, 2, 3, 0);
    repeat (66000) tick();
    chk("stall_saturated", DW'(stall_cycles), DW'(16'hFFFF));
    chk("sat_out_data", out_data, d0);

    // asynchronous reset mid-stream
    #2 reset_n = 1'b0;
    #1;
    chk("async_out_valid", DW'(out_valid), '0);
    chk("async_out_data", out_data, '0);
    chk("async_stall", DW'(stall_cycles), '0);
    chk("async_in_ready", DW'(in_ready), '0);
    tick();
    clear_all();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("after_reset_stall", DW'(stall_cycles), '0);
    exp_q = '{2'd0};
    check_grants("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
